tff_counter_bank: RTL and testbench

//  Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register built

---
 rtl/tff_counter_bank.sv | 43 ++++
 tb/tb_tff_counter_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter_bank.sv
// tff_counter_bank: WIDTH-bit T flip-flop bank with toggle, up/down count and parallel load modes
module tff_counter_bank #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] T,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap
);
   typedef enum logic [1:0] {MODE_TOGGLE = 2'b00, MODE_UP = 2'b01, MODE_DOWN = 2'b10, MODE_LOAD = 2'b11} mode_e;
   logic [WIDTH-1:0] q_q, q_d, t_up, t_dn, t_vec;
   logic             wrap_q, wrap_d;
   assign t_up[0] = 1'b1;
   assign t_dn[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign t_up[i] = &q_q[i-1:0];
      assign t_dn[i] = &(~q_q[i-1:0]);
   end
   always_comb begin
      tc     = (mode == MODE_UP && &q_q) || (mode == MODE_DOWN && ~|q_q);
      t_vec  = mode == MODE_TOGGLE ? T : mode == MODE_UP ? t_up : t_dn;
      q_d    = !en ? q_q : mode == MODE_LOAD ? load_val : (tc && SATURATE) ? q_q : q_q ^ t_vec;
      wrap_d = en && tc && !SATURATE;
   end
   always_ff @(posedge clk) begin
      if (!Reset) begin
         q_q    <= RESET_VAL;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end
   assign Q    = q_q;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_tff_counter_bank.sv
// tb_tff_counter_bank: scoreboard bench over three parameterisations driven by shared stimulus
module tb_tff_counter_bank;
   logic       clk = 1'b0;
   logic       Reset, en;
   logic [1:0] mode;
   logic [3:0] T, load_val;
   logic [3:0] q_a, q_s, q_r;
   logic       tc_a, tc_s, tc_r, w_a, w_s, w_r;
   int         checks = 0;
   int         errors = 0;
   typedef struct packed {
      logic [3:0] qa; logic wa;
      logic [3:0] qs; logic ws;
      logic [3:0] qr; logic wr;
   } exp_t;
   exp_t       sb[$];
   logic [3:0] ma = '0, ms = '0, mr = '0;
   always #5 clk = ~clk;
   tff_counter_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b0)) dut_a (
      .clk(clk), .Reset(Reset), .en(en), .mode(mode), .T(T), .load_val(load_val),
      .Q(q_a), .tc(tc_a), .wrap(w_a));
   tff_counter_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b1)) dut_s (
      .clk(clk), .Reset(Reset), .en(en), .mode(mode), .T(T), .load_val(load_val),
      .Q(q_s), .tc(tc_s), .wrap(w_s));
   tff_counter_bank #(.WIDTH(4), .RESET_VAL(4'b1001), .SATURATE(1'b0)) dut_r (
      .clk(clk), .Reset(Reset), .en(en), .mode(mode), .T(T), .load_val(load_val),
      .Q(q_r), .tc(tc_r), .wrap(w_r));
   function automatic logic [4:0] nxt(input logic [3:0] q, input logic sat, input logic e,
                                      input logic [1:0] m, input logic [3:0] t, input logic [3:0] lv);
      if (!e) return {1'b0, q};
      if (m == 2'd0) return {1'b0, q ^ t};
      if (m == 2'd3) return {1'b0, lv};
      if (m == 2'd1) return (q == 4'hf) ? (sat ? {1'b0, q} : 5'b1_0000) : {1'b0, q + 4'd1};
      return (q == 4'h0) ? (sat ? {1'b0, q} : 5'b1_1111) : {1'b0, q - 4'd1};
   endfunction
   task automatic drive(input logic rn, input logic e, input logic [1:0] m,
                        input logic [3:0] t, input logic [3:0] lv);
      logic [4:0] a, s, r;
      Reset = rn; en = e; mode = m; T = t; load_val = lv;
      a = rn ? nxt(ma, 1'b0, e, m, t, lv) : 5'b0_0000;
      s = rn ? nxt(ms, 1'b1, e, m, t, lv) : 5'b0_0000;
      r = rn ? nxt(mr, 1'b0, e, m, t, lv) : 5'b0_1001;
      ma = a[3:0]; ms = s[3:0]; mr = r[3:0];
      sb.push_back('{a[3:0], a[4], s[3:0], s[4], r[3:0], r[4]});
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      logic [3:0] exp_q [3] = '{4'd1, 4'd2, 4'd3};
      exp_t x;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 2'd1, 4'hf, 4'hf);
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL reset_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
      end
      checks++;
      if ({q_a, w_a, q_r, w_r} !== {4'b0000, 1'b0, 4'b1001, 1'b0})
         begin errors++; $display("FAIL reset_val: got %b/%b %b/%b expected 0000/0 1001/0", q_a, w_a, q_r, w_r); end
      checks++;
      if (tc_a !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %b expected 0", tc_a); end
      mode = 2'd2;
      #1;
      checks++;
      if ({tc_a, tc_r} !== 2'b10) begin errors++; $display("FAIL reset_tc_down: got %b expected 10", {tc_a, tc_r}); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 2'd1, 4'h0, 4'h0);
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL count_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
         checks++;
         if (q_a !== exp_q[i]) begin errors++; $display("FAIL count_after_reset: got %b expected %b", q_a, exp_q[i]); end
      end
   endtask
   task automatic test_toggle();
      logic [3:0] t_seq [4] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000};
      logic [1:0] m_seq [4] = '{2'd3, 2'd0, 2'd0, 2'd0};
      logic [3:0] exp_q [4] = '{4'b0000, 4'b1010, 4'b0000, 4'b0000};
      exp_t x;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, m_seq[i], t_seq[i], 4'b0000);
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL toggle_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
         checks++;
         if ({q_a, w_a, tc_a} !== {exp_q[i], 2'b00})
            begin errors++; $display("FAIL toggle: got Q=%b wrap=%b tc=%b expected Q=%b wrap=0 tc=0", q_a, w_a, tc_a, exp_q[i]); end
      end
   endtask
   task automatic test_up_wrap();
      logic [1:0] m_seq [5] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1};
      logic [3:0] exp_q [5] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
      logic       exp_w [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_t x;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, m_seq[i], 4'hf, 4'b1110);
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL up_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
         checks++;
         if ({q_a, w_a} !== {exp_q[i], exp_w[i]})
            begin errors++; $display("FAIL up_wrap: got Q=%b wrap=%b expected Q=%b wrap=%b", q_a, w_a, exp_q[i], exp_w[i]); end
         if (i == 1) begin
            checks++;
            if ({tc_a, tc_s} !== 2'b11) begin errors++; $display("FAIL up_tc: got %b expected 11", {tc_a, tc_s}); end
            mode = 2'd3;
            #1;
            checks++;
            if (tc_a !== 1'b0) begin errors++; $display("FAIL load_tc: got %b expected 0", tc_a); end
         end
         if (i == 2) begin
            checks++;
            if ({q_s, w_s} !== 5'b1111_0) begin errors++; $display("FAIL up_sat: got %b/%b expected 1111/0", q_s, w_s); end
         end
      end
   endtask
   task automatic test_down_wrap();
      logic [1:0] m_seq [4] = '{2'd3, 2'd2, 2'd2, 2'd2};
      logic [3:0] exp_q [4] = '{4'b0001, 4'b0000, 4'b1111, 4'b1110};
      logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_t x;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, m_seq[i], 4'h0, 4'b0001);
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL down_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
         checks++;
         if ({q_a, w_a} !== {exp_q[i], exp_w[i]})
            begin errors++; $display("FAIL down_wrap: got Q=%b wrap=%b expected Q=%b wrap=%b", q_a, w_a, exp_q[i], exp_w[i]); end
         if (i == 1) begin
            checks++;
            if ({tc_a, tc_s} !== 2'b11) begin errors++; $display("FAIL down_tc: got %b expected 11", {tc_a, tc_s}); end
         end
         if (i >= 2) begin
            checks++;
            if ({q_s, w_s} !== 5'b0000_0) begin errors++; $display("FAIL down_sat: got %b/%b expected 0000/0", q_s, w_s); end
         end
      end
   endtask
   task automatic test_enable();
      logic       e_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [1:0] m_seq [4] = '{2'd3, 2'd1, 2'd1, 2'd1};
      logic [3:0] exp_q [4] = '{4'b0101, 4'b0110, 4'b0110, 4'b0111};
      exp_t x;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, e_seq[i], m_seq[i], 4'hf, 4'b0101);
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL enable_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
         checks++;
         if ({q_a, w_a} !== {exp_q[i], 1'b0})
            begin errors++; $display("FAIL enable: got Q=%b wrap=%b expected Q=%b wrap=0", q_a, w_a, exp_q[i]); end
      end
   endtask
   task automatic test_reset_priority();
      exp_t x;
      drive(1'b1, 1'b1, 2'd3, 4'h0, 4'b1011);
      checks++;
      x = sb.size() ? sb.pop_front() : '1;
      if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
         begin errors++; $display("FAIL prio_load_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
      drive(1'b0, 1'b1, 2'd3, 4'h0, 4'b0100);
      checks++;
      x = sb.size() ? sb.pop_front() : '1;
      if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
         begin errors++; $display("FAIL prio_reset_sb: got %b expected %b", {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
      checks++;
      if ({q_a, q_r} !== {4'b0000, 4'b1001})
         begin errors++; $display("FAIL reset_priority: got %b %b expected 0000 1001", q_a, q_r); end
   endtask
   task automatic test_back_to_back();
      exp_t x;
      for (int i = 0; i < 60; i++) begin
         drive($urandom_range(15) != 0, $urandom_range(7) != 0, 2'($urandom_range(3)),
               4'($urandom_range(15)), 4'($urandom_range(15)));
         checks++;
         x = sb.size() ? sb.pop_front() : '1;
         if ({q_a, w_a, q_s, w_s, q_r, w_r} !== x)
            begin errors++; $display("FAIL random_sb[%0d]: got %b expected %b", i, {q_a, w_a, q_s, w_s, q_r, w_r}, x); end
      end
   endtask
   initial begin
      Reset = 1'b0; en = 1'b0; mode = 2'd0; T = '0; load_val = '0;
      #2;
      test_reset();
      test_toggle();
      test_up_wrap();
      test_down_wrap();
      test_enable();
      test_reset_priority();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
